uart_tx_scheduler: RTL

Shares the single `uart_tx` transmitter between three byte sources:
- event frames (motor-state change bytes);
- response frames (replies to commands received by `uart_rx`);
- a periodic status frame (proximity/motor telemetry byte) that the block generates internally every `PERIOD_CYCLES` cycles.

It sits between the command/telemetry logic and `uart_tx`, and drives `uart_tx`'s valid/ready port. Arbitration is round-robin, each frame is held stable until the transmitter accepts it, and an optional idle gap is inserted between frames.

---
 rtl/uart_sched_pkg.sv | 15 +
 rtl/rr_arbiter3.sv | 28 ++
 rtl/uart_tx_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam logic [1:0] REQ_EVT  = 2'd0;
  localparam logic [1:0] REQ_RSP  = 2'd1;
  localparam logic [1:0] REQ_STAT = 2'd2;
  localparam int         NUM_REQ  = 3;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: the first requester after last_grant wins.
module rr_arbiter3
  import uart_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_idx
);

  logic [1:0] cand;

  // Walk candidates from lowest to highest priority so the nearest one after last_grant is kept.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = 2'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between event, response and periodic status frames
// with round-robin arbitration and an optional idle gap after each frame.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       evt_valid,
  input  logic [7:0] evt_data,
  output logic       evt_ready,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  output logic       rsp_ready,
  input  logic [7:0] status_byte,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] overrun_cnt
);

  localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t       state;
  logic [1:0]         last_grant;
  logic [PW-1:0]      per_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               stat_pend;
  logic               tick;
  logic               stat_grant;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         gnt_idx;

  assign req        = {stat_pend, rsp_valid, evt_valid};
  assign tick       = (per_cnt == PER_LAST);
  assign stat_grant = (state == IDLE) && gnt[REQ_STAT];
  assign busy       = (state != IDLE);

  // Ready is gated by rst_n so it stays low while reset is held with a valid pending.
  assign evt_ready  = rst_n && (state == IDLE) && gnt[REQ_EVT];
  assign rsp_ready  = rst_n && (state == IDLE) && gnt[REQ_RSP];

  rr_arbiter3 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) per_cnt <= '0;
    else        per_cnt <= tick ? '0 : per_cnt + 1'b1;
  end

  // A tick coinciding with a status grant re-arms the flag without counting an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pend   <= 1'b0;
      overrun_cnt <= '0;
    end else if (tick) begin
      stat_pend <= 1'b1;
      if (stat_pend && !stat_grant && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 1'b1;
    end else if (stat_grant) begin
      stat_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_STAT;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= SEND;
            tx_valid   <= 1'b1;
            last_grant <= gnt_idx;
            case (gnt_idx)
              REQ_EVT: tx_data <= evt_data;
              REQ_RSP: tx_data <= rsp_data;
              default: tx_data <= status_byte;
            endcase
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
